ibex_regfile_init_ctrl: RTL
===========================

# ibex_regfile_init_ctrl

Write-port controller for the FPGA register file, which has no reset of its own. After reset, and on request, it sweeps every architectural register to `WordZeroVal`. Outside a sweep it arbitrates the single regfile write port between core writeback (high priority) and a debug write requester (low priority). It sits between writeback/debug and the regfile `waddr_a_i`/`wdata_a_i`/`we_a_i` inputs.

## Interface
Parameters:
- `RV32E`, default 0: 1 selects 16 registers, 0 selects 32.
- `DataWidth`, default 32: register width.
- `WordZeroVal`, default '0: value written during a sweep.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `init_req_i`  in  1  request a re-sweep; sampled in IDLE only.
- `core_waddr_i`  in  5  core writeback address.
- `core_wdata_i`  in  DataWidth  core writeback data.
- `core_we_i`  in  1  core writeback enable.
- `dbg_req_i`  in  1  debug write request.
- `dbg_waddr_i`  in  5  debug write address.
- `dbg_wdata_i`  in  DataWidth  debug write data.
- `dbg_gnt_o`  out  1  debug write accepted this cycle; combinational.
- `rf_waddr_o`  out  5  to regfile `waddr_a_i`.
- `rf_wdata_o`  out  DataWidth  to regfile `wdata_a_i`.
- `rf_we_o`  out  1  to regfile `we_a_i`.
- `busy_o`  out  1  sweep pending or in progress; core must stall writeback.
- `err_o`  out  1  registered pulse: core write dropped during a sweep.

## Operation
- NUM_WORDS = 16 if `RV32E`, else 32.
- Address counter `cnt` is 5 bits; only the low log2(NUM_WORDS) bits are used.

States:
- START:
  - Reset state.
  - `rf_we_o`=0, `busy_o`=1, `dbg_gnt_o`=0.
  - Goes to CLEAR unconditionally at the next edge, with `cnt`←1.
- CLEAR:
  - `rf_we_o`=1, `rf_waddr_o`=`cnt`, `rf_wdata_o`=`WordZeroVal`, `busy_o`=1, `dbg_gnt_o`=0.
  - If `cnt`==NUM_WORDS-1, go to IDLE; else `cnt`←`cnt`+1.
  - x0 is never written; the regfile masks it in any case.
- IDLE: `busy_o`=0.
  - `core_we_i`=1: pass the core address, data and enable through; `dbg_gnt_o`=0.
  - Else if `dbg_req_i`=1: pass the debug address and data through; `rf_we_o`=1, `dbg_gnt_o`=1.
  - Else: `rf_we_o`=0. `rf_waddr_o` and `rf_wdata_o` follow the core inputs.
  - `init_req_i`=1 at an edge: go to CLEAR with `cnt`←1. Core or debug writes in that same cycle still complete.

Rules and boundary conditions:
- `init_req_i` in START or CLEAR is ignored; it is not queued.
- `core_we_i`=1 while `busy_o`=1: the write is dropped and `err_o`=1 in the next cycle for exactly one cycle per offending cycle.
- `dbg_req_i` in START or CLEAR: not granted. The requester holds `dbg_req_i` until `dbg_gnt_o`.
- Writes to address 0 in IDLE are forwarded unchanged.
- Reset asserted mid-sweep or mid-write:
  - State goes to START immediately and `err_o` clears.
  - A full sweep restarts after release.
- Reset values:
  - State START, `cnt`=1, `err_o`=0.
  - Outputs follow START: `rf_we_o`=0, `busy_o`=1, `dbg_gnt_o`=0.
  - `rf_waddr_o`=0, `rf_wdata_o`=`WordZeroVal`.

## Timing
- Edge E1 is the first rising `clk_i` edge after `rst_ni` rises.
- Cycle k is the cycle that ends at edge E(k+1).
- Cycle 0 is START.
- Cycles 1..NUM_WORDS-1 are CLEAR, writing x1..x(N-1); each write commits at the end of its cycle.
- `busy_o` falls at cycle 32 (RV32E: cycle 16).
- Re-sweep: `init_req_i` high in IDLE cycle t:
  - `busy_o`=1 in cycles t+1..t+NUM_WORDS-1.
  - IDLE resumes at t+NUM_WORDS.
- Sweep length is NUM_WORDS-1 cycles, with no dead cycle between CLEAR and IDLE.
- `dbg_gnt_o` and the `rf_*` outputs are combinational from state and inputs; the regfile adds zero extra latency.
- `err_o` has 1-cycle latency.

## Test plan
- Reset release, RV32E=0: `rf_we_o`=1 with `rf_waddr_o`=1..31 on cycles 1..31, data 0. `busy_o`=0 from cycle 32. Reading any register via the regfile returns 0.
- RV32E=1, `WordZeroVal`=32'hDEAD_BEEF: 15 writes of DEADBEEF to addresses 1..15. `busy_o` falls at cycle 16.
- IDLE, `core_we_i`=1 addr 5 data 0x1234 together with `dbg_req_i`=1 addr 6: the core write is forwarded and `dbg_gnt_o`=0. Next cycle, with `core_we_i`=0: the debug write to addr 6 is forwarded and `dbg_gnt_o`=1.
- `core_we_i`=1 during CLEAR cycle 10: `rf_waddr_o`=10, data 0. `err_o`=1 in cycle 11 only. The core data never appears on `rf_wdata_o`.
- `init_req_i` pulsed in IDLE cycle 40 together with a core write to x7: x7 is written in cycle 40, then cleared during the sweep in cycles 41..71. `init_req_i` pulsed again at cycle 50 is ignored.
- `rst_ni` asserted at CLEAR `cnt`=20: outputs go to reset values asynchronously. After release, the sweep restarts at addr 1.

Source files
------------

// File: rtl/ibex_regfile_init_ctrl.sv
// Write-port controller for a reset-less FPGA register file: sweeps x1..x(N-1) to WordZeroVal
// after reset or on request, otherwise muxes core writeback (priority) and debug writes.
module ibex_regfile_init_ctrl #(
  parameter bit                    RV32E       = 1'b0,
  parameter int unsigned           DataWidth   = 32,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_we_i,
  input  logic                 dbg_req_i,
  input  logic [4:0]           dbg_waddr_i,
  input  logic [DataWidth-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

  // Debug handshake: the requester holds dbg_req_i (with stable address/data)
  // until dbg_gnt_o is seen high; the write commits on that same edge.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CLEAR = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  state_e     r_state;
  logic [4:0] r_cnt;
  logic       r_err;
  logic       w_busy;

  assign w_busy = (r_state != ST_IDLE);
  assign busy_o = w_busy;
  assign err_o  = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_START;
      r_cnt   <= 5'd1;
      r_err   <= 1'b0;
    end else begin
      // A core write while busy is dropped; flag it for one cycle per offence.
      r_err <= core_we_i & w_busy;
      case (r_state)
        ST_START: begin
          r_state <= ST_CLEAR;
          r_cnt   <= 5'd1;
        end
        ST_CLEAR: begin
          if (r_cnt == LastAddr) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_IDLE: begin
          if (init_req_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= 5'd1;
          end
        end
        default: begin
          r_state <= ST_START;
          r_cnt   <= 5'd1;
        end
      endcase
    end
  end

  always_comb begin
    dbg_gnt_o  = 1'b0;
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = WordZeroVal;
    case (r_state)
      ST_CLEAR: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_cnt;
        rf_wdata_o = WordZeroVal;
      end
      ST_IDLE: begin
        if (core_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = core_waddr_i;
          rf_wdata_o = core_wdata_i;
        end else if (dbg_req_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = dbg_waddr_i;
          rf_wdata_o = dbg_wdata_i;
          dbg_gnt_o  = 1'b1;
        end else begin
          rf_waddr_o = core_waddr_i;
          rf_wdata_o = core_wdata_i;
        end
      end
      default: begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = WordZeroVal;
      end
    endcase
  end

endmodule
